// File: rtl/cycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/exec/mem/writeback,
// bounds memory waits with a timeout and counts retired instructions.
module cycle_ctrl #(
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [1:0]  MEM_LD_CODE = 2'b01
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Run,
    input  logic        Imem_ack,
    input  logic        Dmem_ack,
    input  logic [1:0]  Mem_we,
    input  logic [1:0]  Mem_out_sel,
    input  logic        Wb_en,
    input  logic [2:0]  If_branch,
    input  logic        If_jump,
    input  logic        Branch_taken,
    output logic        Imem_req,
    output logic        Ir_we,
    output logic        Dmem_req,
    output logic [1:0]  Dmem_wr,
    output logic        Rf_we,
    output logic        Pc_we,
    output logic        Pc_sel,
    output logic [2:0]  State,
    output logic [31:0] Instret,
    output logic        Err
);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned IR_W  = 32;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] ERROR  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [IR_W-1:0]  instret_q, instret_d;

    logic       imem_req_c, ir_we_c, dmem_req_c, rf_we_c, pc_we_c, pc_sel_c;
    logic [1:0] dmem_wr_c;
    logic       is_mem_c, timed_out_c;

    assign is_mem_c    = (Mem_we != 2'b00) || (Mem_out_sel == MEM_LD_CODE);
    assign timed_out_c = (wait_q == TIMEOUT_CNT);

    // State, wait counter and retire counter
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    // Next state and strobe decode; an ack always wins over the timeout check
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        instret_d  = instret_q;
        imem_req_c = 1'b0;
        ir_we_c    = 1'b0;
        dmem_req_c = 1'b0;
        dmem_wr_c  = 2'b00;
        rf_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        pc_sel_c   = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req_c = Run;
                if (!Run) begin
                    wait_d = '0;
                end else if (Imem_ack) begin
                    ir_we_c = 1'b1;
                    state_d = DECODE;
                end else if (timed_out_c) begin
                    state_d = ERROR;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                if (is_mem_c) begin
                    state_d = MEM;
                    wait_d  = '0;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                dmem_req_c = 1'b1;
                dmem_wr_c  = Mem_we;
                if (Dmem_ack) begin
                    state_d = WB;
                end else if (timed_out_c) begin
                    state_d = ERROR;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            WB: begin
                rf_we_c   = Wb_en;
                pc_we_c   = 1'b1;
                pc_sel_c  = If_jump | ((If_branch != 3'd0) & Branch_taken);
                instret_d = instret_q + IR_W'(1);
                state_d   = FETCH;
                wait_d    = '0;
            end
            ERROR: state_d = ERROR;
            default: begin
                state_d = FETCH;
                wait_d  = '0;
            end
        endcase
    end

    // Reset gates every strobe so nothing can pulse while Rst_n is low
    assign Imem_req = Rst_n & imem_req_c;
    assign Ir_we    = Rst_n & ir_we_c;
    assign Dmem_req = Rst_n & dmem_req_c;
    assign Dmem_wr  = Rst_n ? dmem_wr_c : 2'b00;
    assign Rf_we    = Rst_n & rf_we_c;
    assign Pc_we    = Rst_n & pc_we_c;
    assign Pc_sel   = Rst_n & pc_sel_c;
    assign State    = state_q;
    assign Instret  = instret_q;
    assign Err      = (state_q == ERROR);

endmodule

// File: tb/tb_cycle_ctrl.sv
// Self-checking bench for cycle_ctrl: directed vector table, corner-case
// sequences and randomized instructions against a phase-length model.
module tb_cycle_ctrl;
    localparam int unsigned TO = 4;
    localparam logic [1:0]  LD = 2'b01;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Run, Imem_ack, Dmem_ack, Wb_en, If_jump, Branch_taken;
    logic [1:0]  Mem_we, Mem_out_sel;
    logic [2:0]  If_branch;
    logic        Imem_req, Ir_we, Dmem_req, Rf_we, Pc_we, Pc_sel, Err;
    logic [1:0]  Dmem_wr;
    logic [2:0]  State;
    logic [31:0] Instret;

    always #5 Clk = ~Clk;

    cycle_ctrl #(.TIMEOUT(TO), .MEM_LD_CODE(LD)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Imem_ack(Imem_ack), .Dmem_ack(Dmem_ack),
        .Mem_we(Mem_we), .Mem_out_sel(Mem_out_sel), .Wb_en(Wb_en), .If_branch(If_branch),
        .If_jump(If_jump), .Branch_taken(Branch_taken), .Imem_req(Imem_req), .Ir_we(Ir_we),
        .Dmem_req(Dmem_req), .Dmem_wr(Dmem_wr), .Rf_we(Rf_we), .Pc_we(Pc_we), .Pc_sel(Pc_sel),
        .State(State), .Instret(Instret), .Err(Err)
    );

    typedef struct packed {
        logic run, iack, dack;
        logic [1:0] mem_we, sel;
        logic wb;
        logic [2:0] br;
        logic j, taken;
    } in_t;

    typedef struct packed {
        logic imem_req, ir_we, dmem_req;
        logic [1:0] dmem_wr;
        logic rf_we, pc_we, pc_sel;
        logic [2:0] state;
        logic err;
    } out_t;

    typedef struct {
        in_t         in;
        out_t        exp;
        logic [31:0] instret;
        string       name;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_instret = '0;
    out_t        act;
    vec_t        tbl[$];

    assign act = {Imem_req, Ir_we, Dmem_req, Dmem_wr, Rf_we, Pc_we, Pc_sel, State, Err};

    function automatic in_t mk_in(logic run, logic iack, logic dack, logic [1:0] mw,
                                  logic [1:0] sel, logic wb, logic [2:0] br, logic j, logic tk);
        return {run, iack, dack, mw, sel, wb, br, j, tk};
    endfunction

    function automatic out_t o(logic imem, logic ir, logic dreq, logic [1:0] dwr, logic rf,
                               logic pcwe, logic pcsel, logic [2:0] st, logic err);
        return {imem, ir, dreq, dwr, rf, pcwe, pcsel, st, err};
    endfunction

    task automatic drive(input in_t i);
        Run = i.run; Imem_ack = i.iack; Dmem_ack = i.dack;
        Mem_we = i.mem_we; Mem_out_sel = i.sel; Wb_en = i.wb;
        If_branch = i.br; If_jump = i.j; Branch_taken = i.taken;
    endtask

    task automatic check_out(input out_t e, input string nm);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: outputs got %b want %b (imem,ir,dreq,dwr,rf,pcwe,pcsel,state,err)", nm, act, e);
        end
    endtask

    task automatic check_ir(input logic [31:0] e, input string nm);
        n_cmp++;
        if (Instret !== e) begin
            n_bad++;
            $display("FAIL %s: Instret got %0d want %0d", nm, Instret, e);
        end
    endtask

    // One clock cycle: drive at edge+1, compare near the falling edge
    task automatic cyc(input in_t i, input out_t e, input string nm);
        drive(i);
        #4;
        check_out(e, nm);
        check_ir(exp_instret, {nm, "/instret"});
        @(posedge Clk); #1;
    endtask

    // Instruction-level model: phase lengths come from the wait counts
    task automatic run_instr(input in_t dec, input int g, input int fw, input int dw, input string nm);
        in_t  i;
        logic mem, ps;
        i   = dec;
        mem = (dec.mem_we != 2'b00) || (dec.sel == LD);
        ps  = dec.j | ((dec.br != 3'd0) & dec.taken);
        for (int k = 0; k < g; k++) begin
            i.run = 1'b0; i.iack = 1'($urandom); i.dack = 1'($urandom);
            cyc(i, o(0,0,0,2'b00,0,0,0,3'd0,0), {nm, "/idle"});
        end
        for (int k = 0; k < fw; k++) begin
            i.run = 1'b1; i.iack = 1'b0; i.dack = 1'($urandom);
            cyc(i, o(1,0,0,2'b00,0,0,0,3'd0,0), {nm, "/fetch_wait"});
        end
        i.run = 1'b1; i.iack = 1'b1; i.dack = 1'($urandom);
        cyc(i, o(1,1,0,2'b00,0,0,0,3'd0,0), {nm, "/fetch_ack"});
        i.run = 1'($urandom); i.iack = 1'($urandom); i.dack = 1'($urandom);
        cyc(i, o(0,0,0,2'b00,0,0,0,3'd1,0), {nm, "/decode"});
        i.run = 1'($urandom); i.iack = 1'($urandom); i.dack = 1'($urandom);
        cyc(i, o(0,0,0,2'b00,0,0,0,3'd2,0), {nm, "/exec"});
        if (mem) begin
            for (int k = 0; k < dw; k++) begin
                i.run = 1'($urandom); i.iack = 1'($urandom); i.dack = 1'b0;
                cyc(i, o(0,0,1,dec.mem_we,0,0,0,3'd3,0), {nm, "/mem_wait"});
            end
            i.dack = 1'b1;
            cyc(i, o(0,0,1,dec.mem_we,0,0,0,3'd3,0), {nm, "/mem_ack"});
        end
        i.run = 1'($urandom); i.iack = 1'($urandom); i.dack = 1'($urandom);
        cyc(i, o(0,0,0,2'b00,dec.wb,1,ps,3'd4,0), {nm, "/wb"});
        exp_instret = exp_instret + 32'd1;
    endtask

    task automatic add(input in_t i, input out_t e, input logic [31:0] ir, input string nm);
        vec_t v;
        v.in = i; v.exp = e; v.instret = ir; v.name = nm;
        tbl.push_back(v);
    endtask

    initial begin
        in_t  i, dec;
        out_t zero_s0;
        zero_s0 = o(0,0,0,2'b00,0,0,0,3'd0,0);

        // Directed table: ADD, BEQ taken/not taken, JAL, SW with 3 waits
        add(mk_in(0,0,0,2'b00,2'b00,0,3'd0,0,0), zero_s0, 0, "idle");
        add(mk_in(1,1,0,2'b00,2'b00,1,3'd0,0,0), o(1,1,0,2'b00,0,0,0,3'd0,0), 0, "add_fetch");
        add(mk_in(1,1,1,2'b00,2'b00,1,3'd0,0,0), o(0,0,0,2'b00,0,0,0,3'd1,0), 0, "add_decode");
        add(mk_in(1,1,1,2'b00,2'b00,1,3'd0,0,0), o(0,0,0,2'b00,0,0,0,3'd2,0), 0, "add_exec");
        add(mk_in(1,1,1,2'b00,2'b00,1,3'd0,0,0), o(0,0,0,2'b00,1,1,0,3'd4,0), 0, "add_wb");
        add(mk_in(1,1,0,2'b00,2'b00,0,3'd1,0,1), o(1,1,0,2'b00,0,0,0,3'd0,0), 1, "beqt_fetch");
        add(mk_in(0,0,0,2'b00,2'b00,0,3'd1,0,1), o(0,0,0,2'b00,0,0,0,3'd1,0), 1, "beqt_decode");
        add(mk_in(0,0,0,2'b00,2'b00,0,3'd1,0,1), o(0,0,0,2'b00,0,0,0,3'd2,0), 1, "beqt_exec");
        add(mk_in(0,0,0,2'b00,2'b00,0,3'd1,0,1), o(0,0,0,2'b00,0,1,1,3'd4,0), 1, "beqt_wb");
        add(mk_in(1,1,0,2'b00,2'b00,0,3'd1,0,0), o(1,1,0,2'b00,0,0,0,3'd0,0), 2, "beqn_fetch");
        add(mk_in(1,0,0,2'b00,2'b00,0,3'd1,0,0), o(0,0,0,2'b00,0,0,0,3'd1,0), 2, "beqn_decode");
        add(mk_in(1,0,0,2'b00,2'b00,0,3'd1,0,0), o(0,0,0,2'b00,0,0,0,3'd2,0), 2, "beqn_exec");
        add(mk_in(1,0,0,2'b00,2'b00,0,3'd1,0,0), o(0,0,0,2'b00,0,1,0,3'd4,0), 2, "beqn_wb");
        add(mk_in(1,1,0,2'b00,2'b00,1,3'd0,1,0), o(1,1,0,2'b00,0,0,0,3'd0,0), 3, "jal_fetch");
        add(mk_in(0,0,0,2'b00,2'b00,1,3'd0,1,0), o(0,0,0,2'b00,0,0,0,3'd1,0), 3, "jal_decode");
        add(mk_in(0,0,0,2'b00,2'b00,1,3'd0,1,0), o(0,0,0,2'b00,0,0,0,3'd2,0), 3, "jal_exec");
        add(mk_in(0,0,0,2'b00,2'b00,1,3'd0,1,0), o(0,0,0,2'b00,1,1,1,3'd4,0), 3, "jal_wb");
        add(mk_in(1,1,0,2'b11,2'b00,0,3'd0,0,0), o(1,1,0,2'b00,0,0,0,3'd0,0), 4, "sw_fetch");
        add(mk_in(1,0,0,2'b11,2'b00,0,3'd0,0,0), o(0,0,0,2'b00,0,0,0,3'd1,0), 4, "sw_decode");
        add(mk_in(1,0,0,2'b11,2'b00,0,3'd0,0,0), o(0,0,0,2'b00,0,0,0,3'd2,0), 4, "sw_exec");
        add(mk_in(1,1,0,2'b11,2'b00,0,3'd0,0,0), o(0,0,1,2'b11,0,0,0,3'd3,0), 4, "sw_mem_w1");
        add(mk_in(1,1,0,2'b11,2'b00,0,3'd0,0,0), o(0,0,1,2'b11,0,0,0,3'd3,0), 4, "sw_mem_w2");
        add(mk_in(1,1,0,2'b11,2'b00,0,3'd0,0,0), o(0,0,1,2'b11,0,0,0,3'd3,0), 4, "sw_mem_w3");
        add(mk_in(1,1,1,2'b11,2'b00,0,3'd0,0,0), o(0,0,1,2'b11,0,0,0,3'd3,0), 4, "sw_mem_ack");
        add(mk_in(1,1,1,2'b11,2'b00,0,3'd0,0,0), o(0,0,0,2'b00,0,1,0,3'd4,0), 4, "sw_wb");
        add(mk_in(0,1,1,2'b00,2'b00,0,3'd0,0,0), zero_s0, 5, "idle_after");

        // Reset in progress with Run high: nothing may be requested
        Rst_n = 1'b0;
        drive(mk_in(1,1,1,2'b11,2'b01,1,3'd1,1,1));
        #3;
        check_out(zero_s0, "reset_hold");
        check_ir(32'd0, "reset_hold/instret");
        @(posedge Clk); #1;
        Rst_n = 1'b1;

        foreach (tbl[k]) begin
            exp_instret = tbl[k].instret;
            cyc(tbl[k].in, tbl[k].exp, tbl[k].name);
        end

        // Acks arriving exactly when the counter equals TIMEOUT
        run_instr(mk_in(0,0,0,2'b00,LD,1,3'd0,0,0), 0, TO, TO, "lw_at_timeout");

        for (int n = 0; n < 150; n++) begin
            dec = mk_in(0,0,0, 2'($urandom), 2'($urandom), 1'($urandom),
                        3'($urandom), 1'($urandom), 1'($urandom));
            run_instr(dec, $urandom_range(0, 2), $urandom_range(0, TO),
                      $urandom_range(0, TO), "rand");
        end

        // Reset asserted in the middle of a store access
        dec = mk_in(0,0,0,2'b11,2'b00,0,3'd0,0,0);
        i = dec; i.run = 1'b1; i.iack = 1'b1;
        cyc(i, o(1,1,0,2'b00,0,0,0,3'd0,0), "rstmem_fetch");
        i.iack = 1'b0;
        cyc(i, o(0,0,0,2'b00,0,0,0,3'd1,0), "rstmem_decode");
        cyc(i, o(0,0,0,2'b00,0,0,0,3'd2,0), "rstmem_exec");
        i.run = 1'b0; i.dack = 1'b0;
        drive(i);
        #2;
        check_out(o(0,0,1,2'b11,0,0,0,3'd3,0), "rstmem_in_mem");
        Rst_n = 1'b0;
        #1;
        exp_instret = 32'd0;
        check_out(zero_s0, "rstmem_async_drop");
        check_ir(exp_instret, "rstmem_async_drop/instret");
        @(posedge Clk); #1;
        cyc(i, zero_s0, "rstmem_held");
        Rst_n = 1'b1;
        for (int k = 0; k < 3; k++) cyc(i, zero_s0, "rstmem_run_low");
        run_instr(mk_in(0,0,0,2'b00,2'b00,1,3'd0,0,0), 0, 0, 0, "after_rst");

        // Fetch never acknowledged: ERROR after TIMEOUT+1 waiting cycles, sticky
        i = mk_in(1,0,0,2'b00,2'b00,1,3'd0,0,0);
        for (int k = 0; k <= int'(TO); k++) cyc(i, o(1,0,0,2'b00,0,0,0,3'd0,0), "to_wait");
        for (int k = 0; k < 100; k++) begin
            i = mk_in(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                      1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
            cyc(i, o(0,0,0,2'b00,0,0,0,3'd5,1), "err_hold");
        end
        Rst_n = 1'b0;
        #1;
        exp_instret = 32'd0;
        check_out(zero_s0, "err_reset");
        check_ir(exp_instret, "err_reset/instret");
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        cyc(mk_in(0,0,0,2'b00,2'b00,0,3'd0,0,0), zero_s0, "err_cleared");
        run_instr(mk_in(0,0,0,2'b00,2'b00,1,3'd0,0,0), 0, 1, 0, "post_err");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cycle_ctrl.md
CYCLE_CTRL -- requirements
Module: cycle_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, sets the maximum wait cycles for a memory acknowledge (8-bit compare).
REQ-002 Parameter MEM_LD_CODE, default 2'b01, is the Mem_out_sel value that marks a load.
REQ-003 Clk  input  1  rising-edge clock.
REQ-004 Rst_n  input  1  asynchronous active-low reset.
REQ-005 Run  input  1  permits a new instruction fetch.
REQ-006 Imem_ack  input  1  instruction memory data valid.
REQ-007 Dmem_ack  input  1  data memory access complete.
REQ-008 Mem_we  input  2  decoder store width; 0 = no store.
REQ-009 Mem_out_sel  input  2  decoder writeback source.
REQ-010 Wb_en  input  1  decoder register write enable.
REQ-011 If_branch  input  3  decoder branch type; 0 = not a branch.
REQ-012 If_jump  input  1  decoder jump flag.
REQ-013 Branch_taken  input  1  branch comparator result.
REQ-014 Imem_req  output  1  instruction fetch request.
REQ-015 Ir_we  output  1  instruction register load strobe.
REQ-016 Dmem_req  output  1  data memory request.
REQ-017 Dmem_wr  output  2  store width forwarded to data memory.
REQ-018 Rf_we  output  1  register file write strobe.
REQ-019 Pc_we  output  1  PC update strobe.
REQ-020 Pc_sel  output  1  PC source: 0 = PC+4, 1 = branch/jump target.
REQ-021 State  output  3  current FSM state, for debug.
REQ-022 Instret  output  32  count of retired instructions.
REQ-023 Err  output  1  sticky memory-timeout error.

Function
REQ-024 The FSM SHALL have these states and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERROR=5; encodings 6 and 7 SHALL go to FETCH on the next clock.
REQ-025 FETCH behaviour:
- Imem_req=Run.
- Run=1 and Imem_ack=1: Ir_we=1 in that same cycle (combinational), next state DECODE.
- Run=0: remain in FETCH; all strobes 0; wait counter held at 0.
REQ-026 DECODE SHALL last exactly one cycle, then go to EXEC.
REQ-027 EXEC SHALL last exactly one cycle.
- Mem_we!=0 or Mem_out_sel==MEM_LD_CODE: next state MEM.
- Otherwise: next state WB.
REQ-028 MEM behaviour:
- Dmem_req=1 and Dmem_wr=Mem_we, held until Dmem_ack.
- Dmem_ack=1: next state WB.
REQ-029 WB SHALL last exactly one cycle, then go to FETCH.
- Rf_we=Wb_en.
- Pc_we=1.
- Pc_sel=If_jump | (If_branch!=0 & Branch_taken).
- Instret increments by 1, wrapping 0xFFFFFFFF -> 0.
REQ-030 Pc_sel SHALL be 0 in every state other than WB.
REQ-031 All strobes SHALL be 0 outside their stated conditions, and Imem_req and Dmem_req SHALL never be asserted together.
REQ-032 The 8-bit wait counter SHALL behave as follows:
- Clears on entry to FETCH or MEM.
- Increments on each FETCH (Run=1) or MEM cycle without an ack.
- Waiting with counter==TIMEOUT and no ack: next state ERROR.
REQ-033 An ack arriving in the same cycle that the counter reaches TIMEOUT SHALL take precedence, and no error SHALL occur.
REQ-034 In ERROR:
- Err=1.
- All request and strobe outputs are 0.
- Instret is frozen.
- The block leaves ERROR only on reset.
REQ-035 Instruction latency without wait states SHALL be 4 cycles for non-memory instructions and 5 cycles for memory instructions (FETCH-with-ack to WB inclusive).
REQ-036 Decoder inputs SHALL be sampled in the cycle of use and are stable from DECODE through WB.

Reset
REQ-037 Rst_n=0 SHALL immediately force:
- State=FETCH.
- Wait counter=0, Instret=0, Err=0.
- All request and strobe outputs 0.
REQ-038 Reset SHALL override every state, including mid-MEM access and ERROR, and no strobe SHALL glitch during reset.
REQ-039 After Rst_n deasserts, the first fetch request SHALL appear in the first cycle in which Run=1.

Verification
REQ-040 ADD, Run=1, Imem_ack=1 on the first cycle:
- Ir_we in cycle 0.
- States 1, 2, 4 follow.
- Cycle 3: Rf_we=1, Pc_we=1, Pc_sel=0.
- Instret 0 -> 1.
REQ-041 SW (Mem_we=2'b11, Wb_en=0), Dmem_ack after 3 wait cycles:
- MEM lasts 4 cycles with Dmem_wr=2'b11.
- WB has Rf_we=0, Pc_we=1.
REQ-042 BEQ with Branch_taken=1 -> Pc_sel=1 in WB; the same case with Branch_taken=0 -> Pc_sel=0; JAL -> Pc_sel=1, Rf_we=1.
REQ-043 Imem_ack never asserted, TIMEOUT=4:
- ERROR is entered after the 5th waiting cycle, Err=1.
- The state persists for 100 cycles.
- Rst_n pulse clears it.
REQ-044 Ack exactly at counter==TIMEOUT -> normal progress, Err=0.
REQ-045 Rst_n asserted mid-MEM:
- Dmem_req drops asynchronously.
- State=0, Instret=0.
- With Run=0 held, no Imem_req.
